// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Shared memory bus between the fetch/data arbiter and the memory system.
// One transaction is in flight at a time. mem_valid pulses for one cycle.
// mem_addr, mem_wdata and mem_wstrb are held until mem_ready.
//
// Signals:
//   mem_valid  request pulse (arbiter -> memory)
//   mem_instr  1 = instruction fetch transaction
//   mem_addr   XLEN bus address
//   mem_wdata  XLEN write data
//   mem_wstrb  XLEN/8 byte strobes, 0 = read
//   mem_rdata  XLEN read data (memory -> arbiter)
//   mem_ready  completion (memory -> arbiter)
//
// Modports: master = arbiter side, slave = memory side.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
  parameter int XLEN = 32
);
  logic              mem_valid;
  logic              mem_instr;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the core's single memory bus between instruction fetch and the
// decode-stage data request (load / store / fence). It latches single-cycle
// request pulses, arbitrates, issues registered bus requests and routes the
// response back with a registered one-cycle ready pulse.
//
// Configuration macro: ROUND_ROBIN_EN
//   defined   : on contention the last-granted requester loses
//               (out of reset fetch counts as last-granted)
//   undefined : fixed priority, data always wins
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   i_valid/i_addr        fetch request pulse and address
//   i_flush               drop pending fetch / suppress in-flight fetch reply
//   i_rdata/i_ready       fetch data and completion pulse
//   d_valid/d_fence       data request pulse, fence qualifier
//   d_addr/d_wdata/d_wstrb data address, store data, strobes (0 = load)
//   d_rdata/d_ready       load data (0 for fence) and completion pulse
//   bus                   memory bus, master modport
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int XLEN = 32
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              i_valid,
  input  logic [XLEN-1:0]   i_addr,
  input  logic              i_flush,
  output logic [XLEN-1:0]   i_rdata,
  output logic              i_ready,

  input  logic              d_valid,
  input  logic              d_fence,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_wstrb,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_ready,

  mem_port_arbiter_if.master bus
);

  localparam int SW = XLEN / 8;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, FENCE} state_t;

  state_t          state;
  logic            ipend;
  logic            dpend;
  logic            cancel;
  logic [XLEN-1:0] i_addr_q;
  logic [XLEN-1:0] d_addr_q;
  logic [XLEN-1:0] d_wdata_q;
  logic [SW-1:0]   d_wstrb_q;
  logic            d_fence_q;
`ifdef ROUND_ROBIN_EN
  logic            last_i;
`endif

  logic            cancel_eff;
  logic            i_done;
  logic            d_done;
  logic            ip_n;
  logic            dp_n;
  logic            arb_en;
  logic            prefer_d;
  logic            pick_d;
  logic            pick_i;
  logic [XLEN-1:0] i_addr_e;
  logic [XLEN-1:0] d_addr_e;
  logic [XLEN-1:0] d_wdata_e;
  logic [SW-1:0]   d_wstrb_e;
  logic            d_fence_e;

  // Next-cycle pending flags and the grant decision. Arbitration runs in the
  // cycle a transaction completes, so a waiting request issues right after
  // mem_ready with no idle bubble. Same-cycle captures bypass the latches.
  always_comb begin
    // NOTE: every signal gets its default at the top of the block so no
    // path leaves one unassigned, which would infer a latch.
    cancel_eff = cancel | i_flush;
    i_done     = (state == BUSY_I) && bus.mem_ready;
    d_done     = (state == BUSY_D) && bus.mem_ready;

    // A cancelled fetch completing must not clear ipend: by then ipend can
    // only hold a fresh request made with or after the flush.
    ip_n = (ipend & ~i_flush) | i_valid;
    if (i_done && !cancel_eff) ip_n = 1'b0;

    dp_n = dpend | d_valid;
    if (d_done || state == FENCE) dp_n = 1'b0;

    arb_en = (state == IDLE) || (state == FENCE) || i_done || d_done;

`ifdef ROUND_ROBIN_EN
    prefer_d = last_i;
`else
    prefer_d = 1'b1;
`endif
    pick_d = arb_en && dp_n && (!ip_n || prefer_d);
    pick_i = arb_en && ip_n && !pick_d;

    i_addr_e  = i_valid ? i_addr  : i_addr_q;
    d_addr_e  = d_valid ? d_addr  : d_addr_q;
    d_wdata_e = d_valid ? d_wdata : d_wdata_q;
    d_wstrb_e = d_valid ? d_wstrb : d_wstrb_q;
    d_fence_e = d_valid ? d_fence : d_fence_q;
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= IDLE;
      ipend         <= 1'b0;
      dpend         <= 1'b0;
      cancel        <= 1'b0;
      // NOTE: the request latches are reset too; they are only ever read
      // behind a pending flag, but a known value keeps the bus outputs clean.
      i_addr_q      <= '0;
      d_addr_q      <= '0;
      d_wdata_q     <= '0;
      d_wstrb_q     <= '0;
      d_fence_q     <= 1'b0;
`ifdef ROUND_ROBIN_EN
      last_i        <= 1'b1;
`endif
      i_rdata       <= '0;
      i_ready       <= 1'b0;
      d_rdata       <= '0;
      d_ready       <= 1'b0;
      bus.mem_valid <= 1'b0;
      bus.mem_instr <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_wstrb <= '0;
    end else begin
      bus.mem_valid <= 1'b0;
      i_ready       <= 1'b0;
      d_ready       <= 1'b0;
      ipend         <= ip_n;
      dpend         <= dp_n;

      if (i_valid) i_addr_q <= i_addr;
      if (d_valid) begin
        d_addr_q  <= d_addr;
        d_wdata_q <= d_wdata;
        d_wstrb_q <= d_wstrb;
        d_fence_q <= d_fence;
      end

      if (state == BUSY_I && i_flush) cancel <= 1'b1;

      case (state)
        BUSY_I: if (bus.mem_ready) begin
          state  <= IDLE;
          cancel <= 1'b0;
          if (!cancel_eff) begin
            i_ready <= 1'b1;
            i_rdata <= bus.mem_rdata;
          end
        end
        BUSY_D: if (bus.mem_ready) begin
          state   <= IDLE;
          d_ready <= 1'b1;
          d_rdata <= bus.mem_rdata;
        end
        FENCE: begin
          state   <= IDLE;
          d_ready <= 1'b1;
          d_rdata <= '0;
        end
        default: ;
      endcase

      // Grants override the state return above.
      if (pick_d) begin
`ifdef ROUND_ROBIN_EN
        last_i <= 1'b0;
`endif
        if (d_fence_e) begin
          state <= FENCE;
        end else begin
          state         <= BUSY_D;
          bus.mem_valid <= 1'b1;
          bus.mem_instr <= 1'b0;
          bus.mem_addr  <= d_addr_e;
          bus.mem_wdata <= d_wdata_e;
          bus.mem_wstrb <= d_wstrb_e;
        end
      end else if (pick_i) begin
`ifdef ROUND_ROBIN_EN
        last_i <= 1'b1;
`endif
        state         <= BUSY_I;
        bus.mem_valid <= 1'b1;
        bus.mem_instr <= 1'b1;
        bus.mem_addr  <= i_addr_e;
        bus.mem_wdata <= '0;
        bus.mem_wstrb <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed stimulus with hand-computed expectations pushed into scoreboard
// queues; a negedge monitor pops and compares whenever the DUT presents
// mem_valid, i_ready or d_ready.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int XLEN = 32;

  logic            clock;
  logic            reset;
  logic            i_valid;
  logic [XLEN-1:0] i_addr;
  logic            i_flush;
  logic [XLEN-1:0] i_rdata;
  logic            i_ready;
  logic            d_valid;
  logic            d_fence;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [3:0]      d_wstrb;
  logic [XLEN-1:0] d_rdata;
  logic            d_ready;

  mem_port_arbiter_if #(.XLEN(XLEN)) bus ();

  mem_port_arbiter #(.XLEN(XLEN)) dut (
    .clock   (clock),
    .reset   (reset),
    .i_valid (i_valid),
    .i_addr  (i_addr),
    .i_flush (i_flush),
    .i_rdata (i_rdata),
    .i_ready (i_ready),
    .d_valid (d_valid),
    .d_fence (d_fence),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_wstrb (d_wstrb),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .bus     (bus.master)
  );

  typedef struct {
    int          cyc;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        chk_wdata;
  } bus_ev_t;

  typedef struct {
    int          cyc;
    logic [31:0] data;
  } rdy_ev_t;

  bus_ev_t q_bus[$];
  rdy_ev_t q_i[$];
  rdy_ev_t q_d[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_bus(input int c, input logic instr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb, input logic chk);
    bus_ev_t e;
    e.cyc = c; e.instr = instr; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb; e.chk_wdata = chk;
    q_bus.push_back(e);
  endtask

  task automatic exp_i(input int c, input logic [31:0] data);
    rdy_ev_t e;
    e.cyc = c; e.data = data;
    q_i.push_back(e);
  endtask

  task automatic exp_d(input int c, input logic [31:0] data);
    rdy_ev_t e;
    e.cyc = c; e.data = data;
    q_d.push_back(e);
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  bus_ev_t be;
  rdy_ev_t re;
  always @(negedge clock) begin
    if (bus.mem_valid === 1'b1) begin
      if (q_bus.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_mem_valid: got mem_valid addr 0x%0h at cycle %0d, expected none",
                 bus.mem_addr, cyc);
      end else begin
        be = q_bus.pop_front();
        check("bus_cycle", 64'(cyc), 64'(be.cyc));
        check("bus_instr", 64'(bus.mem_instr), 64'(be.instr));
        check("bus_addr", 64'(bus.mem_addr), 64'(be.addr));
        check("bus_wstrb", 64'(bus.mem_wstrb), 64'(be.wstrb));
        if (be.chk_wdata) check("bus_wdata", 64'(bus.mem_wdata), 64'(be.wdata));
      end
    end
    if (i_ready === 1'b1) begin
      if (q_i.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_i_ready: got i_ready at cycle %0d, expected none", cyc);
      end else begin
        re = q_i.pop_front();
        check("i_ready_cycle", 64'(cyc), 64'(re.cyc));
        check("i_rdata", 64'(i_rdata), 64'(re.data));
      end
    end
    if (d_ready === 1'b1) begin
      if (q_d.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_d_ready: got d_ready at cycle %0d, expected none", cyc);
      end else begin
        re = q_d.pop_front();
        check("d_ready_cycle", 64'(cyc), 64'(re.cyc));
        check("d_rdata", 64'(d_rdata), 64'(re.data));
      end
    end
  end

  // Protocol checker: a requester must not re-request while its own
  // request is still outstanding (flush retires the fetch request).
  logic i_out, d_out;
  always @(posedge clock) begin
    if (!reset) begin
      i_out <= 1'b0;
      d_out <= 1'b0;
    end else begin
      assert (!(i_valid && i_out && !i_ready && !i_flush))
        else $error("fetch request while one is outstanding");
      assert (!(d_valid && d_out && !d_ready))
        else $error("data request while one is outstanding");
      if (i_valid) i_out <= 1'b1;
      else if (i_ready || i_flush) i_out <= 1'b0;
      if (d_valid) d_out <= 1'b1;
      else if (d_ready) d_out <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    i_valid       = 1'b0;
    i_flush       = 1'b0;
    d_valid       = 1'b0;
    d_fence       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  int t;

  initial begin
    reset = 1'b0;
    i_valid = 1'b0; i_addr = '0; i_flush = 1'b0;
    d_valid = 1'b0; d_fence = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;

    idle(3);
    check("reset_pulses", 64'({i_ready, d_ready, bus.mem_valid, bus.mem_instr}), 64'h0);
    check("reset_rdata", {i_rdata, d_rdata}, 64'h0);
    check("reset_bus_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 64'h0);
    check("reset_bus_wstrb", 64'(bus.mem_wstrb), 64'h0);
    reset = 1'b1;
    idle(2);

    // Fetch at T, mem_ready at T+3 -> mem_valid T+1, i_ready T+4.
    t = cyc;
    i_valid = 1'b1; i_addr = 32'h100;
    exp_bus(t + 1, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0);
    exp_i(t + 4, 32'h13);
    idle(3);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h13;
    idle(3);

    // Store with simultaneous fetch: store first, fetch right after mem_ready.
    t = cyc;
    i_valid = 1'b1; i_addr = 32'h104;
    d_valid = 1'b1; d_addr = 32'h200; d_wdata = 32'hAABBCCDD; d_wstrb = 4'hF;
    exp_bus(t + 1, 1'b0, 32'h200, 32'hAABBCCDD, 4'hF, 1'b1);
    idle(2);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0;
    exp_d(t + 3, 32'h0);
    exp_bus(t + 3, 1'b1, 32'h104, 32'h0, 4'h0, 1'b0);
    idle(2);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h17;
    exp_i(t + 5, 32'h17);
    idle(3);

    // Fetch in flight, load queued, flush, mem_ready: no i_ready, load next cycle.
    t = cyc;
    i_valid = 1'b1; i_addr = 32'h300;
    exp_bus(t + 1, 1'b1, 32'h300, 32'h0, 4'h0, 1'b0);
    tick();
    d_valid = 1'b1; d_addr = 32'h400; d_wdata = 32'h0; d_wstrb = 4'h0;
    tick();
    i_flush = 1'b1;
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD;
    exp_bus(t + 4, 1'b0, 32'h400, 32'h0, 4'h0, 1'b1);
    idle(2);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h12345678;
    exp_d(t + 6, 32'h12345678);
    idle(2);
    // Cancel flag must be gone: a fresh fetch answered the same cycle it issues.
    i_valid = 1'b1; i_addr = 32'h500;
    exp_bus(t + 8, 1'b1, 32'h500, 32'h0, 4'h0, 1'b0);
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h99;
    exp_i(t + 9, 32'h99);
    idle(3);

    // Flush together with a new fetch while busy: old reply dropped, new kept.
    t = cyc;
    i_valid = 1'b1; i_addr = 32'h600;
    exp_bus(t + 1, 1'b1, 32'h600, 32'h0, 4'h0, 1'b0);
    idle(2);
    i_flush = 1'b1; i_valid = 1'b1; i_addr = 32'h700;
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD;
    exp_bus(t + 4, 1'b1, 32'h700, 32'h0, 4'h0, 1'b0);
    idle(2);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h77;
    exp_i(t + 6, 32'h77);
    idle(3);

    // Fence during a fetch: FENCE entered after the fetch, d_ready one later.
    t = cyc;
    i_valid = 1'b1; i_addr = 32'h800;
    exp_bus(t + 1, 1'b1, 32'h800, 32'h0, 4'h0, 1'b0);
    tick();
    d_valid = 1'b1; d_fence = 1'b1; d_addr = 32'h0;
    idle(2);
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h88;
    exp_i(t + 4, 32'h88);
    exp_d(t + 5, 32'h0);
    idle(4);

    // Fence from idle: no bus access, d_ready two cycles after the request.
    t = cyc;
    d_valid = 1'b1; d_fence = 1'b1;
    exp_d(t + 2, 32'h0);
    idle(4);

    // Load and fetch together; the last grant was data (the fence).
    t = cyc;
    d_valid = 1'b1; d_addr = 32'h900; d_wdata = 32'h0; d_wstrb = 4'h0;
    i_valid = 1'b1; i_addr = 32'hA00;
`ifdef ROUND_ROBIN_EN
    exp_bus(t + 1, 1'b1, 32'hA00, 32'h0, 4'h0, 1'b0);
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11;
    exp_i(t + 2, 32'h11);
    exp_bus(t + 2, 1'b0, 32'h900, 32'h0, 4'h0, 1'b1);
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h22;
    exp_d(t + 3, 32'h22);
`else
    exp_bus(t + 1, 1'b0, 32'h900, 32'h0, 4'h0, 1'b1);
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h22;
    exp_d(t + 2, 32'h22);
    exp_bus(t + 2, 1'b1, 32'hA00, 32'h0, 4'h0, 1'b0);
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11;
    exp_i(t + 3, 32'h11);
`endif
    idle(3);

    // Reset while BUSY_D: outputs cleared next cycle, late mem_ready ignored.
    t = cyc;
    d_valid = 1'b1; d_addr = 32'hB00; d_wdata = 32'h1; d_wstrb = 4'h1;
    exp_bus(t + 1, 1'b0, 32'hB00, 32'h1, 4'h1, 1'b1);
    idle(2);
    check("busy_hold_addr", 64'(bus.mem_addr), 64'hB00);
    check("busy_hold_wstrb", 64'(bus.mem_wstrb), 64'h1);
    reset = 1'b0;
    tick();
    check("midreset_pulses", 64'({i_ready, d_ready, bus.mem_valid, bus.mem_instr}), 64'h0);
    check("midreset_bus_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 64'h0);
    check("midreset_bus_wstrb", 64'(bus.mem_wstrb), 64'h0);
    check("midreset_rdata", {i_rdata, d_rdata}, 64'h0);
    reset = 1'b1;
    tick();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h5A;
    tick();
    check("late_ready_ignored", 64'({d_ready, i_ready}), 64'h0);
    idle(3);

    check("bus_queue_drained", 64'(q_bus.size()), 64'h0);
    check("i_queue_drained", 64'(q_i.size()), 64'h0);
    check("d_queue_drained", 64'(q_d.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
